// File: rtl/ambilight_pkg.sv
// Shared FSM encoding, RAM word byte lanes and write-strobe constant for the ambilight zone writer.
package ambilight_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ZONES  = 2'd1,
        ST_STATUS = 2'd2
    } state_e;

    localparam int LANE_TAG = 24;
    localparam int LANE_R   = 16;
    localparam int LANE_G   = 8;
    localparam int LANE_B   = 0;

    localparam logic [3:0] BYTE_EN_ALL = 4'b1111;

    // Status word sits directly after the last zone word.
    function automatic int status_ofs(input int n_zones);
        return n_zones;
    endfunction

endpackage

// File: rtl/ambilight_zone_acc.sv
// One zone's saturating R/G/B accumulators plus the end-of-frame shadow copy.
// Clear drops any pixel arriving that cycle from the accumulator; a snapshot on that cycle includes it.
module ambilight_zone_acc
    import ambilight_pkg::*;
#(
    parameter int SUM_W = 24
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             add_i,
    input  logic [23:0]      rgb_i,
    input  logic             clr_i,
    input  logic             snap_i,
    output logic [SUM_W-1:0] r_o,
    output logic [SUM_W-1:0] g_o,
    output logic [SUM_W-1:0] b_o
);

    logic [SUM_W-1:0] acc_q [3];
    logic [SUM_W-1:0] acc_d [3];
    logic [SUM_W-1:0] shd_q [3];
    logic [7:0]       chan  [3];

    assign chan[0] = rgb_i[LANE_R +: 8];
    assign chan[1] = rgb_i[LANE_G +: 8];
    assign chan[2] = rgb_i[LANE_B +: 8];

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [7:0] b);
        logic [SUM_W:0] wide;
        wide = {1'b0, a} + {{(SUM_W-7){1'b0}}, b};
        return wide[SUM_W] ? '1 : wide[SUM_W-1:0];
    endfunction

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            acc_d[c] = add_i ? sat_add(acc_q[c], chan[c]) : acc_q[c];
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int c = 0; c < 3; c++) begin
                acc_q[c] <= '0;
                shd_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                acc_q[c] <= clr_i ? '0 : acc_d[c];
                if (snap_i) begin
                    shd_q[c] <= acc_d[c];
                end
            end
        end
    end

    assign r_o = shd_q[0];
    assign g_o = shd_q[1];
    assign b_o = shd_q[2];

endmodule

// File: rtl/ambilight_zone_writer.sv
// Accumulates per-zone RGB sums, snapshots them at end of frame and streams averages plus a commit word
// into RAM: zone k written k+1 cycles after the eof edge's start pulse; eofs during a flush are dropped.
module ambilight_zone_writer
    import ambilight_pkg::*;
#(
    parameter int N_ZONES   = 16,
    parameter int ADDR_W    = 13,
    parameter int BASE_ADDR = 0,
    parameter int SUM_W     = 24,
    parameter int PIX_SHIFT = 12,
    localparam int ZONE_W   = $clog2(N_ZONES)
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              pix_valid,
    input  logic [ZONE_W-1:0] pix_zone,
    input  logic [23:0]       pix_rgb,
    input  logic              pix_eof,
    input  logic              overrun_clr,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_clken,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    output logic [3:0]        ram_byteenable,
    output logic              busy,
    output logic              overrun,
    output logic [31:0]       frame_cnt
);

    localparam int STATUS_OFS = status_ofs(N_ZONES);

    state_e              state_q, state_d;
    logic [ZONE_W-1:0]   idx_q, idx_d;
    logic                start_q;
    logic                accept;
    logic [31:0]         frame_cnt_q;
    logic                overrun_q, overrun_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [3:0]          be_q;
    logic [SUM_W-1:0]    shd_r [N_ZONES];
    logic [SUM_W-1:0]    shd_g [N_ZONES];
    logic [SUM_W-1:0]    shd_b [N_ZONES];

    // start_q covers the gap between the eof edge and the FSM leaving IDLE.
    assign accept = pix_eof && (state_q == ST_IDLE) && !start_q;

    for (genvar g = 0; g < N_ZONES; g++) begin : g_zone
        ambilight_zone_acc #(.SUM_W(SUM_W)) u_acc (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .add_i         (pix_valid && (pix_zone == ZONE_W'(g))),
            .rgb_i         (pix_rgb),
            .clr_i         (pix_eof),
            .snap_i        (accept),
            .r_o           (shd_r[g]),
            .g_o           (shd_g[g]),
            .b_o           (shd_b[g])
        );
    end

    function automatic logic [7:0] avg8(input logic [SUM_W-1:0] sum);
        logic [SUM_W-1:0] shifted;
        shifted = sum >> PIX_SHIFT;
        return ((shifted >> 8) != '0) ? 8'hFF : shifted[7:0];
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    state_d = ST_ZONES;
                    idx_d   = '0;
                end
            end
            ST_ZONES: begin
                if (idx_q == ZONE_W'(N_ZONES - 1)) begin
                    state_d = ST_STATUS;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_STATUS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each write lands in the same cycle as its state.
    always_comb begin
        wr_d   = (state_d != ST_IDLE);
        addr_d = '0;
        data_d = '0;
        if (state_d == ST_ZONES) begin
            addr_d                 = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_d);
            data_d[LANE_TAG +: 8]  = frame_cnt_q[7:0];
            data_d[LANE_R +: 8]    = avg8(shd_r[idx_d]);
            data_d[LANE_G +: 8]    = avg8(shd_g[idx_d]);
            data_d[LANE_B +: 8]    = avg8(shd_b[idx_d]);
        end else if (state_d == ST_STATUS) begin
            addr_d = ADDR_W'(BASE_ADDR + STATUS_OFS);
            data_d = frame_cnt_q;
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (pix_eof && !accept) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            start_q     <= 1'b0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            start_q     <= accept;
            frame_cnt_q <= frame_cnt_q + 32'(accept);
            overrun_q   <= overrun_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= wr_d ? BYTE_EN_ALL : 4'b0000;
        end
    end

    assign ram_address    = addr_q;
    assign ram_chipselect = wr_q;
    assign ram_clken      = wr_q;
    assign ram_write      = wr_q;
    assign ram_writedata  = data_q;
    assign ram_byteenable = be_q;
    assign busy           = wr_q;
    assign overrun        = overrun_q;
    assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_ambilight_zone_writer.sv
// Bench for ambilight_zone_writer: two instances (saturating and clamping configurations) against a frame-level model.
module tb_ambilight_zone_writer;

    localparam int NZ_A = 4, NZ_B = 6, BASE_A = 0, BASE_B = 100, SW_A = 10, SW_B = 12, SHIFT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_eof = 1'b0;
    logic        overrun_clr = 1'b0;
    logic [2:0]  zone = '0;
    logic [23:0] rgb = '0;
    logic [1:0]  zone_a;
    assign zone_a = zone[1:0];

    logic [12:0] ram_address_a, ram_address_b;
    logic        ram_chipselect_a, ram_chipselect_b, ram_clken_a, ram_clken_b;
    logic        ram_write_a, ram_write_b, busy_a, busy_b, overrun_a, overrun_b;
    logic [31:0] ram_writedata_a, ram_writedata_b, frame_cnt_a, frame_cnt_b;
    logic [3:0]  ram_byteenable_a, ram_byteenable_b;

    ambilight_zone_writer #(.N_ZONES(NZ_A), .ADDR_W(13), .BASE_ADDR(BASE_A), .SUM_W(SW_A), .PIX_SHIFT(SHIFT)) u_dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n), .pix_valid(pix_valid), .pix_zone(zone_a), .pix_rgb(rgb),
        .pix_eof(pix_eof), .overrun_clr(overrun_clr), .ram_address(ram_address_a),
        .ram_chipselect(ram_chipselect_a), .ram_clken(ram_clken_a), .ram_write(ram_write_a),
        .ram_writedata(ram_writedata_a), .ram_byteenable(ram_byteenable_a), .busy(busy_a),
        .overrun(overrun_a), .frame_cnt(frame_cnt_a));

    ambilight_zone_writer #(.N_ZONES(NZ_B), .ADDR_W(13), .BASE_ADDR(BASE_B), .SUM_W(SW_B), .PIX_SHIFT(SHIFT)) u_dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .pix_valid(pix_valid), .pix_zone(zone), .pix_rgb(rgb),
        .pix_eof(pix_eof), .overrun_clr(overrun_clr), .ram_address(ram_address_b),
        .ram_chipselect(ram_chipselect_b), .ram_clken(ram_clken_b), .ram_write(ram_write_b),
        .ram_writedata(ram_writedata_b), .ram_byteenable(ram_byteenable_b), .busy(busy_b),
        .overrun(overrun_b), .frame_cnt(frame_cnt_b));

    initial forever #5 clk = ~clk;

    function automatic int nz_of(input int d);   return (d == 0) ? NZ_A : NZ_B;   endfunction
    function automatic int base_of(input int d); return (d == 0) ? BASE_A : BASE_B; endfunction
    function automatic int sw_of(input int d);   return (d == 0) ? SW_A : SW_B;     endfunction
    function automatic int chan(input logic [23:0] c, input int ch);
        return int'((c >> (16 - 8 * ch)) & 24'hFF);
    endfunction
    function automatic int avg(input int s);
        return ((s >> SHIFT) > 255) ? 255 : (s >> SHIFT);
    endfunction

    // Frame-level model: sums per zone, snapshot words computed at the accepted eof,
    // then the k-th word of the flush is expected k+1 cycles after that eof edge.
    int        acc [2][8][3];
    bit [31:0] fc [2];
    bit [31:0] words [2][8];
    bit        ovr [2], have [2], exp_wr [2], m_set;
    int        exp_addr [2], m_z, m_k, m_lim;
    bit [31:0] exp_data [2];
    longint    cyc = 0, t0 [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int z = 0; z < 8; z++) for (int c = 0; c < 3; c++) acc[d][z][c] = 0;
                fc[d] = 0; ovr[d] = 0; have[d] = 0; exp_wr[d] = 0; exp_addr[d] = 0; exp_data[d] = 0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                m_z   = (d == 0) ? int'(zone[1:0]) : int'(zone);
                m_lim = (1 << sw_of(d)) - 1;
                m_set = 0;
                if (pix_valid && m_z < nz_of(d))
                    for (int c = 0; c < 3; c++)
                        acc[d][m_z][c] = (acc[d][m_z][c] + chan(rgb, c) > m_lim) ? m_lim : acc[d][m_z][c] + chan(rgb, c);
                if (pix_eof) begin
                    // Status write occupies cycle t0+N+1; only the cycle after it may start a new frame.
                    if (!have[d] || cyc >= t0[d] + nz_of(d) + 3) begin
                        fc[d]++; t0[d] = cyc; have[d] = 1;
                        for (int z = 0; z < nz_of(d); z++)
                            words[d][z] = {fc[d][7:0], 8'(avg(acc[d][z][0])), 8'(avg(acc[d][z][1])), 8'(avg(acc[d][z][2]))};
                        words[d][nz_of(d)] = fc[d];
                    end else begin
                        m_set = 1;
                    end
                    for (int z = 0; z < 8; z++) for (int c = 0; c < 3; c++) acc[d][z][c] = 0;
                end
                ovr[d] = m_set ? 1'b1 : (overrun_clr ? 1'b0 : ovr[d]);
                m_k = int'(cyc - t0[d]) - 1;
                exp_wr[d] = have[d] && m_k >= 0 && m_k <= nz_of(d);
                exp_addr[d] = exp_wr[d] ? base_of(d) + m_k : 0;
                exp_data[d] = exp_wr[d] ? words[d][m_k] : 32'h0;
            end
        end
    end

    int n_checks = 0, n_pass = 0;
    int nwr_a = 0, nwr_b = 0, nbusy_a = 0, nbusy_b = 0;
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        check("wr_a", {ram_write_a, ram_chipselect_a, ram_clken_a, ram_byteenable_a},
              {exp_wr[0], exp_wr[0], exp_wr[0], exp_wr[0] ? 4'hF : 4'h0});
        check("addr_a", ram_address_a, exp_addr[0]);
        check("data_a", ram_writedata_a, exp_data[0]);
        check("busy_a", busy_a, exp_wr[0]);
        check("ovr_a", overrun_a, ovr[0]);
        check("fcnt_a", frame_cnt_a, fc[0]);
        check("wr_b", {ram_write_b, ram_chipselect_b, ram_clken_b, ram_byteenable_b},
              {exp_wr[1], exp_wr[1], exp_wr[1], exp_wr[1] ? 4'hF : 4'h0});
        check("addr_b", ram_address_b, exp_addr[1]);
        check("data_b", ram_writedata_b, exp_data[1]);
        check("busy_b", busy_b, exp_wr[1]);
        check("ovr_b", overrun_b, ovr[1]);
        check("fcnt_b", frame_cnt_b, fc[1]);
        if (ram_write_a) begin mem_a[ram_address_a[7:0]] = ram_writedata_a; nwr_a++; end
        if (ram_write_b) begin mem_b[ram_address_b[7:0]] = ram_writedata_b; nwr_b++; end
        if (busy_a) nbusy_a++;
        if (busy_b) nbusy_b++;
    endtask

    task automatic px(input bit v, input int z, input logic [23:0] c, input bit e, input bit clr);
        tick();
        pix_valid = v; zone = 3'(z); rgb = c; pix_eof = e; overrun_clr = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(0, 0, 24'h0, 0, 0);
    endtask

    task automatic do_reset();
        tick();
        pix_valid = 0; pix_eof = 0; overrun_clr = 0; rst_n = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    int  s_a, s_b, sb_a, sb_b;
    bit  found;

    initial begin
        do_reset();
        idle(2);
        check("rst_fcnt", frame_cnt_a, 32'd0);
        check("rst_wr", ram_write_a, 1'b0);
        check("rst_ovr", overrun_a, 1'b0);

        // 4 pixels of 0x102030 per zone, then eof.
        s_a = nwr_a; s_b = nwr_b; sb_a = nbusy_a; sb_b = nbusy_b;
        for (int z = 0; z < 4; z++) for (int i = 0; i < 4; i++) px(1, z, 24'h102030, 0, 0);
        px(0, 0, 24'h0, 1, 0);
        idle(12);
        check("t1_nwr_a", nwr_a - s_a, 5);
        check("t1_busy_a", nbusy_a - sb_a, 5);
        check("t1_nwr_b", nwr_b - s_b, 7);
        check("t1_busy_b", nbusy_b - sb_b, 7);
        check("t1_z0_a", mem_a[0], 32'h01102030);
        check("t1_z3_a", mem_a[3], 32'h01102030);
        check("t1_stat_a", mem_a[4], 32'h00000001);
        check("t1_z0_b", mem_b[100], 32'h01102030);
        check("t1_z4_b", mem_b[104], 32'h01000000);
        check("t1_stat_b", mem_b[106], 32'h00000001);

        // Saturation (A) and clamp (B) on 8 white pixels in zone 1.
        do_reset();
        for (int i = 0; i < 8; i++) px(1, 1, 24'hFFFFFF, 0, 0);
        px(0, 0, 24'h0, 1, 0);
        idle(12);
        check("sat_z1_a", mem_a[1], 32'h01FFFFFF);
        check("sat_z0_a", mem_a[0], 32'h01000000);
        check("clamp_z1_b", mem_b[101], 32'h01FFFFFF);

        // Second eof two cycles after the first.
        do_reset();
        s_a = nwr_a;
        px(0, 0, 24'h0, 1, 0);
        idle(1);
        px(0, 0, 24'h0, 1, 0);
        idle(12);
        check("ovr_set_a", overrun_a, 1'b1);
        check("ovr_fcnt_a", frame_cnt_a, 32'd1);
        check("ovr_nwr_a", nwr_a - s_a, 5);
        px(0, 0, 24'h0, 1, 0);
        idle(12);
        check("ovr_next_tag_a", mem_a[0], 32'h02000000);

        // Out-of-range zone (B sees 7) and pixel coincident with eof.
        do_reset();
        for (int i = 0; i < 4; i++) px(1, 7, 24'h102030, 0, 0);
        px(1, 0, 24'h102030, 1, 0);
        idle(12);
        check("oor_z0_b", mem_b[100], 32'h0104080C);
        check("oor_z3_b", mem_b[103], 32'h01000000);
        check("oor_z0_a", mem_a[0], 32'h0104080C);
        check("oor_z3_a", mem_a[3], 32'h01102030);

        // Reset during the zone 2 write.
        do_reset();
        s_a = nwr_a;
        px(0, 0, 24'h0, 1, 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            px(0, 0, 24'h0, 0, 0);
            if (ram_write_a && ram_address_a == 13'd2) found = 1;
        end
        check("rmf_reach_z2", found, 1'b1);
        #2 rst_n = 0;
        #1 check("rmf_wr_a", ram_write_a, 1'b0);
        check("rmf_wr_b", ram_write_b, 1'b0);
        tick(); tick();
        rst_n = 1;
        idle(12);
        check("rmf_nwr_a", nwr_a - s_a, 3);
        check("rmf_fcnt_a", frame_cnt_a, 32'd0);

        // Overrun set and clear together, then clear alone.
        do_reset();
        px(0, 0, 24'h0, 1, 0);
        idle(1);
        px(0, 0, 24'h0, 1, 1);
        idle(1);
        check("setclr_ovr_a", overrun_a, 1'b1);
        px(0, 0, 24'h0, 0, 1);
        check("clr_pending_a", overrun_a, 1'b1);
        idle(1);
        check("clr_done_a", overrun_a, 1'b0);
        idle(10);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++)
            px($urandom_range(0, 9) < 7, $urandom_range(0, 7),
               $urandom_range(0, 1) ? 24'hFFFFFF : 24'($urandom),
               $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0);
        idle(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
